pipe_share_arbiter: RTL and testbench
=====================================

// Module: pipe_share_arbiter
// PURPOSE
//  Shares one fixed-latency, fully pipelined datapath between two requesters.
//  - Accepts one operand per cycle and issues it to the datapath.
//  - Carries a {valid,id} tag alongside in a matching delay line.
//  - Steers each returning result to the requester that issued it.
//  - Sits in front of the shared modular-multiply pipeline in the encryption path.
// PARAMETERS
//  DATA_BIT_SIZE  32  operand/result width
//  LATENCY        4   datapath depth in register stages (>=1); datapath has no stall
//  MAX_INFLIGHT   8   max outstanding ops per requester (>=1)
// PORTS
//  clk_in          in   1              clock, rising edge
//  rst_n_in        in   1              reset, asynchronous, active-low
//  req0_valid_in   in   1              requester 0 operand valid
//  req0_data_in    in   DATA_BIT_SIZE  requester 0 operand
//  req0_ready_out  out  1              requester 0 may issue this cycle
//  req1_valid_in   in   1              requester 1 operand valid
//  req1_data_in    in   DATA_BIT_SIZE  requester 1 operand
//  req1_ready_out  out  1              requester 1 may issue this cycle
//  dp_valid_out    out  1              operand valid to datapath (registered)
//  dp_data_out     out  DATA_BIT_SIZE  operand to datapath (registered)
//  dp_data_in      in   DATA_BIT_SIZE  datapath result, LATENCY edges after dp_data_out
//  res0_valid_out  out  1              result for requester 0, one-cycle pulse
//  res1_valid_out  out  1              result for requester 1, one-cycle pulse
//  res_data_out    out  DATA_BIT_SIZE  result data, shared by both res ports
//  idle_out        out  1              no op in flight, both counts zero
// BEHAVIOUR
//  Reset:
//  - Clears every output, both counts and the tag line; idle_out=1 after reset.
//  - RR pointer resets to favour req0.
//  - Reset mid-operation drops in-flight ops; no res pulse is produced for them.
//  Handshake:
//  - A transfer occurs at an edge where valid&ready are both high.
//  - valid must not depend on ready.
//  - Once valid is high, the requester holds it and its data until the transfer.
//  Eligibility and grant:
//  - Requester i is eligible when valid_i=1 and cnt_i<MAX_INFLIGHT.
//  - Grant is combinational. If one requester is eligible, it wins.
//  - If both are eligible, the RR-favoured requester wins.
//  - After each grant, the pointer moves to favour the other requester.
//  - readyN_out = grantN, so at most one ready is high per cycle.
//  Issue:
//  - Transfer at edge k drives dp_valid_out=1 and dp_data_out=operand in cycle k+1.
//  - Tag {1,id} is loaded in cycle k+1. Otherwise dp_valid_out=0 and dp_data_out holds.
//  Return:
//  - Tag line is LATENCY deep and shifts every cycle, so it aligns with dp_data_in.
//  - At edge k+LATENCY+1: res_data_out<=dp_data_in and res{id}_valid_out<=1 for one cycle.
//  - Net latency: accept at edge k -> result visible in cycle after edge k+LATENCY+1.
//  - Back-to-back issue gives back-to-back results in issue order.
//  Counts:
//  - cnt_i is $clog2(MAX_INFLIGHT+1) bits: +1 on issue, -1 on result for i.
//  - Issue and return on the same edge leave the count unchanged. Never over/underflows.
//  - idle_out is registered: 1 when both counts are 0 and no tag is valid.
// CONFIGURATION
//  PIPE_ARB_FIXED_PRIO_EN:
//  - Defined: req0 always wins when both are eligible; RR pointer is removed.
//    req1 can starve.
//  - Undefined (default): round-robin as above.
// STRUCTURE
//  - Package pipe_arb_pkg holds:
//    - typedef req_id_t (1 bit)
//    - typedef struct packed {logic valid; req_id_t id;} arb_tag_t
//    - localparam NUM_REQ=2
//  - Sub-module arb_tag_delay: LATENCY-deep arb_tag_t shift register with async
//    active-low clear, instantiated once for the tag line.
// TESTING
//  1 Reset: rst_n_in=0 mid-stream -> all outputs 0, idle_out=1 after release; dropped ops never pulse res.
//  2 Single op: LATENCY=4, req0 sends 0x11 at edge 10, datapath returns x+1 -> res0_valid_out=1,
//    res_data_out=0x12 in cycle after edge 15; idle_out=1 afterwards.
//  3 Contention: both valid for 6 cycles -> grants alternate 0,1,0,1,0,1; results return in the same
//    order, tagged correctly.
//  4 Credit limit: MAX_INFLIGHT=2, LATENCY=8, req1 streams -> ready drops after 2 issues; it rises in
//    the cycle after the first res1 pulse; cnt1 never exceeds 2.
//  5 Simultaneous issue+return at the limit -> count holds at MAX_INFLIGHT-1 and throughput stays 1/cycle.
//  6 With PIPE_ARB_FIXED_PRIO_EN, both valid for 5 cycles -> req0 granted all 5, req1 none.

Source files
------------

// File: rtl/pipe_arb_pkg.sv
// Shared types for the pipelined-datapath arbiter: requester id, the {valid,id} tag
// that rides alongside each op, and the requester count.
package pipe_arb_pkg;

  localparam int NUM_REQ = 2;

  typedef logic [0:0] req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } arb_tag_t;

endpackage

// File: rtl/arb_tag_delay.sv
// LATENCY-deep shift register for arb_tag_t; busy_o flags any valid tag still in flight.
// The asynchronous clear empties every stage so dropped ops never produce a result.
module arb_tag_delay
  import pipe_arb_pkg::*;
#(
  parameter int LATENCY = 4
) (
  input  logic     clk_i,
  input  logic     rst_n_i,
  input  arb_tag_t tag_i,
  output arb_tag_t tag_o,
  output logic     busy_o
);

  arb_tag_t stage_q [LATENCY];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < LATENCY; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < LATENCY; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tag_o = stage_q[LATENCY-1];

  always_comb begin
    busy_o = 1'b0;
    for (int i = 0; i < LATENCY; i++) begin
      busy_o = busy_o | stage_q[i].valid;
    end
  end

endmodule

// File: rtl/pipe_share_arbiter.sv
// Shares one fixed-latency, no-stall datapath between two credit-limited requesters.
// Build macro PIPE_ARB_FIXED_PRIO_EN: req0 always wins contention, RR pointer removed.
module pipe_share_arbiter
  import pipe_arb_pkg::*;
#(
  parameter int DATA_BIT_SIZE = 32,
  parameter int LATENCY       = 4,
  parameter int MAX_INFLIGHT  = 8
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     req0_valid_in,
  input  logic [DATA_BIT_SIZE-1:0] req0_data_in,
  output logic                     req0_ready_out,
  input  logic                     req1_valid_in,
  input  logic [DATA_BIT_SIZE-1:0] req1_data_in,
  output logic                     req1_ready_out,
  output logic                     dp_valid_out,
  output logic [DATA_BIT_SIZE-1:0] dp_data_out,
  input  logic [DATA_BIT_SIZE-1:0] dp_data_in,
  output logic                     res0_valid_out,
  output logic                     res1_valid_out,
  output logic [DATA_BIT_SIZE-1:0] res_data_out,
  output logic                     idle_out
);

  localparam int               CNT_W   = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0]         cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic                     elig0, elig1, grant0, grant1;
  logic                     dp_valid_q, dp_valid_d;
  logic [DATA_BIT_SIZE-1:0] dp_data_q, dp_data_d;
  req_id_t                  dp_id_q, dp_id_d;
  logic                     res0_q, res0_d, res1_q, res1_d;
  logic [DATA_BIT_SIZE-1:0] res_data_q, res_data_d;
  logic                     idle_q, idle_d;
  arb_tag_t                 tag_in, tag_out;
  logic                     tag_busy;

  // A credit is returned on the result pulse itself, so ready reopens the cycle after it.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                input logic             inc,
                                                input logic             dec);
    logic [CNT_W-1:0] nxt;
    nxt = cnt;
    if (inc && !dec)      nxt = cnt + CNT_ONE;
    else if (!inc && dec) nxt = cnt - CNT_ONE;
    return nxt;
  endfunction

  assign elig0 = req0_valid_in && (cnt0_q < CNT_MAX);
  assign elig1 = req1_valid_in && (cnt1_q < CNT_MAX);

`ifdef PIPE_ARB_FIXED_PRIO_EN
  assign grant0 = elig0;
  assign grant1 = elig1 && !elig0;
`else
  logic rr_q, rr_d;  // 1 favours req1 on the next contention

  assign grant0 = elig0 && (!elig1 || !rr_q);
  assign grant1 = elig1 && (!elig0 ||  rr_q);

  always_comb begin
    rr_d = rr_q;
    if (grant0)      rr_d = 1'b1;
    else if (grant1) rr_d = 1'b0;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) rr_q <= 1'b0;
    else           rr_q <= rr_d;
  end
`endif

  assign req0_ready_out = grant0;
  assign req1_ready_out = grant1;

  always_comb begin
    dp_valid_d = grant0 || grant1;
    dp_id_d    = req_id_t'(grant1);
    dp_data_d  = dp_data_q;
    if (grant0)      dp_data_d = req0_data_in;
    else if (grant1) dp_data_d = req1_data_in;
  end

  // Tag enters the line one cycle after issue so its last stage lines up with dp_data_in.
  assign tag_in = '{valid: dp_valid_q, id: dp_id_q};

  arb_tag_delay #(
    .LATENCY (LATENCY)
  ) u_tag_delay (
    .clk_i   (clk_in),
    .rst_n_i (rst_n_in),
    .tag_i   (tag_in),
    .tag_o   (tag_out),
    .busy_o  (tag_busy)
  );

  always_comb begin
    res0_d     = tag_out.valid && (tag_out.id == 1'b0);
    res1_d     = tag_out.valid && (tag_out.id == 1'b1);
    res_data_d = tag_out.valid ? dp_data_in : res_data_q;
  end

  always_comb begin
    cnt0_d = cnt_next(cnt0_q, grant0, res0_q);
    cnt1_d = cnt_next(cnt1_q, grant1, res1_q);
    idle_d = (cnt0_d == '0) && (cnt1_d == '0) && !tag_busy;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      dp_valid_q <= 1'b0;
      dp_data_q  <= '0;
      dp_id_q    <= '0;
      res0_q     <= 1'b0;
      res1_q     <= 1'b0;
      res_data_q <= '0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
      idle_q     <= 1'b1;
    end else begin
      dp_valid_q <= dp_valid_d;
      dp_data_q  <= dp_data_d;
      dp_id_q    <= dp_id_d;
      res0_q     <= res0_d;
      res1_q     <= res1_d;
      res_data_q <= res_data_d;
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
      idle_q     <= idle_d;
    end
  end

  assign dp_valid_out   = dp_valid_q;
  assign dp_data_out    = dp_data_q;
  assign res0_valid_out = res0_q;
  assign res1_valid_out = res1_q;
  assign res_data_out   = res_data_q;
  assign idle_out       = idle_q;

endmodule

// File: tb/tb_pipe_share_arbiter.sv
// Scoreboard bench: instance A (LATENCY=4, MAX_INFLIGHT=7) and instance B (LATENCY=8,
// MAX_INFLIGHT=2), each fed by a behavioural x+1 datapath.
module tb_pipe_share_arbiter;

  localparam int W  = 32;
  localparam int LA = 4;
  localparam int MA = 7;
  localparam int LB = 8;
  localparam int MB = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         a_v0, a_v1, a_r0, a_r1, a_dpv, a_res0, a_res1, a_idle;
  logic [W-1:0] a_d0, a_d1, a_dpo, a_dpi, a_resd;
  logic         b_v0, b_v1, b_r0, b_r1, b_dpv, b_res0, b_res1, b_idle;
  logic [W-1:0] b_d0, b_d1, b_dpo, b_dpi, b_resd;

  pipe_share_arbiter #(.DATA_BIT_SIZE(W), .LATENCY(LA), .MAX_INFLIGHT(MA)) u_a (
    .clk_in(clk), .rst_n_in(rst_n),
    .req0_valid_in(a_v0), .req0_data_in(a_d0), .req0_ready_out(a_r0),
    .req1_valid_in(a_v1), .req1_data_in(a_d1), .req1_ready_out(a_r1),
    .dp_valid_out(a_dpv), .dp_data_out(a_dpo), .dp_data_in(a_dpi),
    .res0_valid_out(a_res0), .res1_valid_out(a_res1), .res_data_out(a_resd),
    .idle_out(a_idle));

  pipe_share_arbiter #(.DATA_BIT_SIZE(W), .LATENCY(LB), .MAX_INFLIGHT(MB)) u_b (
    .clk_in(clk), .rst_n_in(rst_n),
    .req0_valid_in(b_v0), .req0_data_in(b_d0), .req0_ready_out(b_r0),
    .req1_valid_in(b_v1), .req1_data_in(b_d1), .req1_ready_out(b_r1),
    .dp_valid_out(b_dpv), .dp_data_out(b_dpo), .dp_data_in(b_dpi),
    .res0_valid_out(b_res0), .res1_valid_out(b_res1), .res_data_out(b_resd),
    .idle_out(b_idle));

  // Datapath models: result is operand+1, LATENCY edges after it is presented.
  logic [W-1:0] a_pipe [LA];
  logic [W-1:0] b_pipe [LB];
  always @(posedge clk) begin
    a_pipe[0] <= a_dpo + 32'd1;
    for (int i = 1; i < LA; i++) a_pipe[i] <= a_pipe[i-1];
    b_pipe[0] <= b_dpo + 32'd1;
    for (int i = 1; i < LB; i++) b_pipe[i] <= b_pipe[i-1];
  end
  assign a_dpi = a_pipe[LA-1];
  assign b_dpi = b_pipe[LB-1];

  typedef struct packed {
    logic         id;
    logic [W-1:0] data;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   checks = 0;
  int   errors = 0;
  int   pulses_a = 0;
  int   pulses_b = 0;

  always @(negedge clk) begin
    if (rst_n && (a_res0 || a_res1)) begin
      pulses_a++;
      checks++;
      if (a_res0 && a_res1) begin
        errors++;
        $display("FAIL mon_a_onehot res0=%0b res1=%0b required one pulse", a_res0, a_res1);
      end else if (qa.size() == 0) begin
        errors++;
        $display("FAIL mon_a_unexpected id=%0d data=%h required no result", a_res1, a_resd);
      end else begin
        ea = qa.pop_front();
        if (ea.id !== a_res1 || ea.data !== a_resd) begin
          errors++;
          $display("FAIL mon_a_result id=%0d data=%h required id=%0d data=%h",
                   a_res1, a_resd, ea.id, ea.data);
        end
      end
    end
    if (rst_n && (b_res0 || b_res1)) begin
      pulses_b++;
      checks++;
      if (b_res0 && b_res1) begin
        errors++;
        $display("FAIL mon_b_onehot res0=%0b res1=%0b required one pulse", b_res0, b_res1);
      end else if (qb.size() == 0) begin
        errors++;
        $display("FAIL mon_b_unexpected id=%0d data=%h required no result", b_res1, b_resd);
      end else begin
        eb = qb.pop_front();
        if (eb.id !== b_res1 || eb.data !== b_resd) begin
          errors++;
          $display("FAIL mon_b_result id=%0d data=%h required id=%0d data=%h",
                   b_res1, b_resd, eb.id, eb.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Called at a negedge: drive, sample the combinational ready before the edge, push
  // expectations for any transfer, return at the following negedge.
  task automatic a_cycle(input logic v0, input logic [W-1:0] d0, input logic v1,
                         input logic [W-1:0] d1, output logic g0, output logic g1);
    a_v0 = v0; a_d0 = d0; a_v1 = v1; a_d1 = d1;
    #1;
    g0 = a_r0;
    g1 = a_r1;
    if (g0) qa.push_back('{id: 1'b0, data: d0 + 32'd1});
    if (g1) qa.push_back('{id: 1'b1, data: d1 + 32'd1});
    @(negedge clk);
  endtask

  task automatic b_cycle(input logic v0, input logic [W-1:0] d0, input logic v1,
                         input logic [W-1:0] d1, output logic g0, output logic g1);
    b_v0 = v0; b_d0 = d0; b_v1 = v1; b_d1 = d1;
    #1;
    g0 = b_r0;
    g1 = b_r1;
    if (g0) qb.push_back('{id: 1'b0, data: d0 + 32'd1});
    if (g1) qb.push_back('{id: 1'b1, data: d1 + 32'd1});
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    a_v0 = 1'b0; a_v1 = 1'b0; a_d0 = '0; a_d1 = '0;
    b_v0 = 1'b0; b_v1 = 1'b0; b_d0 = '0; b_d1 = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    qa.delete();
    qb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((qa.size() + qb.size()) != 0 && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(name, 32'(qa.size() + qb.size()), 32'd0);
  endtask

  logic g0, g1;
  int   i0, i1;

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_dp_valid", 32'(a_dpv), 32'd0);
    chk("rst_dp_data", a_dpo, 32'd0);
    chk("rst_res", 32'({a_res0, a_res1, b_res0, b_res1}), 32'd0);
    chk("rst_res_data", a_resd, 32'd0);
    chk("rst_idle", 32'({a_idle, b_idle}), 32'd3);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_idle_after", 32'(a_idle), 32'd1);

    // Single op: result 0x12 visible five edges after the accepting edge
    a_cycle(1'b1, 32'h11, 1'b0, '0, g0, g1);
    a_v0 = 1'b0;
    chk("t2_grant", 32'({g0, g1}), 32'd2);
    chk("t2_dp_valid", 32'(a_dpv), 32'd1);
    chk("t2_dp_data", a_dpo, 32'h11);
    chk("t2_busy", 32'(a_idle), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 1) begin
        chk("t2_dp_valid_drop", 32'(a_dpv), 32'd0);
        chk("t2_dp_data_hold", a_dpo, 32'h11);
      end
      if (i < 5) chk("t2_res_early", 32'(a_res0), 32'd0);
    end
    chk("t2_res0", 32'(a_res0), 32'd1);
    chk("t2_res_data", a_resd, 32'h12);
    @(negedge clk);
    chk("t2_pulse_end", 32'(a_res0), 32'd0);
    chk("t2_idle", 32'(a_idle), 32'd1);

`ifdef PIPE_ARB_FIXED_PRIO_EN
    // Fixed priority: req0 takes all five contended cycles, req1 only afterwards
    do_reset();
    i0 = 0;
    i1 = 0;
    for (int c = 0; c < 6; c++) begin
      a_cycle(i0 < 5, 32'hA0 + 32'(i0), 1'b1, 32'hB0 + 32'(i1), g0, g1);
      chk("t6_grant0", 32'(g0), (c < 5) ? 32'd1 : 32'd0);
      chk("t6_grant1", 32'(g1), (c < 5) ? 32'd0 : 32'd1);
      if (g0) i0++;
      if (g1) i1++;
    end
    clear_inputs();
    wait_drain("t6_drain");
`else
    // Contention: grants alternate 0,1,0,1,0 then req1 alone
    do_reset();
    i0 = 0;
    i1 = 0;
    for (int c = 0; c < 6; c++) begin
      a_cycle(i0 < 3, 32'hA0 + 32'(i0), i1 < 3, 32'hB0 + 32'(i1), g0, g1);
      chk("t3_grant0", 32'(g0), (c % 2 == 0) ? 32'd1 : 32'd0);
      chk("t3_grant1", 32'(g1), (c % 2 == 1) ? 32'd1 : 32'd0);
      if (g0) i0++;
      if (g1) i1++;
    end
    clear_inputs();
    wait_drain("t3_drain");
`endif

    // Streaming at full rate: count settles at MAX_INFLIGHT-1 and ready never drops
    do_reset();
    for (int k = 0; k < 12; k++) begin
      a_cycle(1'b1, 32'h100 + 32'(k), 1'b0, '0, g0, g1);
      chk("t5_ready", 32'(g0), 32'd1);
      chk("t5_not_idle", 32'(a_idle), 32'd0);
      if (k >= 5) chk("t5_cnt_hold", 32'(u_a.cnt0_q), 32'(MA - 1));
    end
    clear_inputs();
    wait_drain("t5_drain");
    repeat (2) @(negedge clk);
    chk("t5_idle", 32'(a_idle), 32'd1);

    // Reset mid-stream: in-flight ops are dropped without result pulses
    do_reset();
    for (int k = 0; k < 3; k++) a_cycle(1'b1, 32'h300 + 32'(k), 1'b0, '0, g0, g1);
    b_cycle(1'b0, '0, 1'b1, 32'h400, g0, g1);
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    qa.delete();
    qb.delete();
    #1;
    chk("t1_dp_clear", 32'({a_dpv, b_dpv}), 32'd0);
    chk("t1_data_clear", a_resd | a_dpo | b_dpo, 32'd0);
    chk("t1_res_clear", 32'({a_res0, a_res1, b_res0, b_res1}), 32'd0);
    chk("t1_idle_in_rst", 32'({a_idle, b_idle}), 32'd3);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t1_idle_release", 32'({a_idle, b_idle}), 32'd3);
    pulses_a = 0;
    pulses_b = 0;
    repeat (15) @(negedge clk);
    chk("t1_no_res", 32'(pulses_a + pulses_b), 32'd0);

    // Credit limit on B: two issues, then ready reopens the cycle after the first res1 pulse
    do_reset();
    i1 = 0;
    for (int c = 0; c < 14; c++) begin
      b_cycle(1'b0, '0, 1'b1, 32'h200 + 32'(i1), g0, g1);
      chk("t4_ready1", 32'(g1), (c < 2 || c == 11 || c == 12) ? 32'd1 : 32'd0);
      chk("t4_ready0", 32'(g0), 32'd0);
      chk("t4_res1", 32'(b_res1), (c == 9 || c == 10) ? 32'd1 : 32'd0);
      if (c >= 1) chk("t4_cnt_max", 32'(u_b.cnt1_q <= 2'(MB)), 32'd1);
      if (g1) i1++;
    end
    clear_inputs();
    wait_drain("t4_drain");

    chk("end_queues", 32'(qa.size() + qb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
